// File: rtl/axi_pkg.sv
// Shared AXI4 types, protocol limits and response-ordering helper used by the
// DMA request/burst logic.
package axi_pkg;

    localparam int AXI_LEN_BC_WIDTH    = 32;
    localparam int AXI_4K_BOUNDARY     = 4096;
    localparam int AXI_MAX_INCR_BEATS  = 256;
    localparam int AXI_MAX_FIXED_BEATS = 16;
    localparam int AXI_MAX_EXCL_BEATS  = 16;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CPL,
        ST_DONE
    } dma_req_state_e;

    function automatic logic [1:0] axi_resp_rank(input axi_resp_e r);
        logic [1:0] rank;
        case (r)
            RESP_DECERR: rank = 2'd3;
            RESP_SLVERR: rank = 2'd2;
            RESP_EXOKAY: rank = 2'd1;
            default:     rank = 2'd0;
        endcase
        return rank;
    endfunction

    // Severity order DECERR > SLVERR > EXOKAY > OKAY.
    function automatic axi_resp_e axi_resp_worst(input axi_resp_e a, input axi_resp_e b);
        return (axi_resp_rank(b) > axi_resp_rank(a)) ? b : a;
    endfunction

endpackage

// File: rtl/axi_dma_burst_calc.sv
// Combinational sizing of the next AR burst from the current address and the
// number of beats still to be requested.
module axi_dma_burst_calc
    import axi_pkg::*;
#(
    parameter int AW = 32,
    parameter int BC = 4
) (
    input  logic [AW-1:0]               addr,
    input  logic [AXI_LEN_BC_WIDTH-1:0] rem,
    input  logic                        fixed,
    output logic [8:0]                  beats,
    output logic [7:0]                  ar_len
);

    localparam int SIZE = $clog2(BC);
    localparam int LW   = AXI_LEN_BC_WIDTH;

    logic [12:0] room_bytes;
    logic [12:0] room_beats;
    logic [12:0] cap;

    always_comb begin
        room_bytes = 13'(AXI_4K_BOUNDARY) - {1'b0, addr[11:0]};
        room_beats = room_bytes >> SIZE;
        if (fixed) begin
            cap = 13'(AXI_MAX_FIXED_BEATS);
        end else if (room_beats < 13'(AXI_MAX_INCR_BEATS)) begin
            cap = room_beats;
        end else begin
            cap = 13'(AXI_MAX_INCR_BEATS);
        end

        if (rem < {{(LW-13){1'b0}}, cap}) begin
            beats = 9'(rem);
        end else begin
            beats = 9'(cap);
        end

        // With nothing left to issue the AR length field idles at zero.
        ar_len = (beats == 9'd0) ? 8'd0 : 8'(beats - 9'd1);
    end

endmodule

// File: rtl/axi_dma_req_burst_gen.sv
// Accepts one DMA transfer request, splits it into legal AXI4 AR bursts, tracks
// outstanding burst completions and returns one aggregated response.
module axi_dma_req_burst_gen
    import axi_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int ID_W            = 1,
    parameter int AR_ID           = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [AW-1:0]               req_addr,
    input  logic [AXI_LEN_BC_WIDTH-1:0] req_byte_len,
    input  logic                        req_fixed,
    input  logic                        req_lock,
    output logic                        req_resp_valid,
    output logic [1:0]                  req_resp,
    output logic                        ar_valid,
    input  logic                        ar_ready,
    output logic [AW-1:0]               ar_addr,
    output logic [7:0]                  ar_len,
    output logic [2:0]                  ar_size,
    output logic [1:0]                  ar_burst,
    output logic                        ar_lock,
    output logic [ID_W-1:0]             ar_id,
    input  logic                        cpl_valid,
    input  logic [1:0]                  cpl_resp
);

    localparam int BC    = DW / 8;
    localparam int SIZE  = $clog2(BC);
    localparam int LW    = AXI_LEN_BC_WIDTH;
    localparam int LW1   = LW + 1;
    localparam int CNT_W = 4;

    dma_req_state_e    state;
    dma_req_state_e    state_next;
    logic [AW-1:0]     cur_addr;
    logic [LW-1:0]     rem;
    logic              fixed_q;
    logic              lock_q;
    axi_resp_e         agg;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;

    logic [8:0]        beats;
    logic [7:0]        len_calc;
    logic [LW-1:0]     rem_after;
    logic              acc;
    logic              ar_hs;
    logic              cpl_take;
    logic              bad_align;
    logic              bad_lock;
    logic              acc_err;
    logic [LW:0]       end_off;
    axi_resp_e         cpl_eff;

    axi_dma_burst_calc #(
        .AW (AW),
        .BC (BC)
    ) u_calc (
        .addr   (cur_addr),
        .rem    (rem),
        .fixed  (fixed_q),
        .beats  (beats),
        .ar_len (len_calc)
    );

    assign req_ready      = (state == ST_IDLE);
    assign req_resp_valid = (state == ST_DONE);
    assign req_resp       = agg;
    assign ar_valid       = (state == ST_ISSUE) && (outstanding != CNT_W'(MAX_OUTSTANDING));
    assign ar_addr        = cur_addr;
    assign ar_len         = len_calc;
    assign ar_size        = 3'(SIZE);
    assign ar_burst       = fixed_q ? BURST_FIXED : BURST_INCR;
    assign ar_lock        = lock_q;
    assign ar_id          = ID_W'(AR_ID);

    assign acc       = req_valid && req_ready;
    assign ar_hs     = ar_valid && ar_ready;
    assign cpl_take  = cpl_valid && (outstanding != '0)
                       && ((state == ST_ISSUE) || (state == ST_WAIT_CPL));
    assign rem_after = rem - {{(LW-9){1'b0}}, beats};

    // Exclusive bursts must fit in one AXI burst and stay inside one 4KB page.
    assign bad_align = (|req_addr[SIZE-1:0]) || (|req_byte_len[SIZE-1:0]);
    assign end_off   = {{(LW1-12){1'b0}}, req_addr[11:0]} + {1'b0, req_byte_len};
    assign bad_lock  = req_lock && ((req_byte_len > LW'(AXI_MAX_EXCL_BEATS * BC))
                       || (!req_fixed && (end_off > LW1'(AXI_4K_BOUNDARY))));
    assign acc_err   = bad_align || bad_lock;

    // EXOKAY only carries meaning for an exclusive request.
    always_comb begin
        cpl_eff = axi_resp_e'(cpl_resp);
        if (cpl_eff == RESP_EXOKAY && !lock_q) begin
            cpl_eff = RESP_OKAY;
        end
    end

    always_comb begin
        outstanding_next = outstanding;
        if (ar_hs && !cpl_take) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!ar_hs && cpl_take) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (acc) begin
                    if (acc_err || (req_byte_len == '0)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (ar_hs && (rem_after == '0)) begin
                    state_next = ST_WAIT_CPL;
                end
            end
            ST_WAIT_CPL: begin
                if (outstanding_next == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr    <= '0;
            rem         <= '0;
            fixed_q     <= 1'b0;
            lock_q      <= 1'b0;
            agg         <= RESP_OKAY;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (acc) begin
                cur_addr <= req_addr;
                fixed_q  <= req_fixed;
                lock_q   <= req_lock;
                rem      <= acc_err ? '0 : (req_byte_len >> SIZE);
                agg      <= acc_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (ar_hs) begin
                    rem <= rem_after;
                    if (!fixed_q) begin
                        cur_addr <= cur_addr + (AW'(beats) << SIZE);
                    end
                end
                if (cpl_take) begin
                    agg <= axi_resp_worst(agg, cpl_eff);
                end
                if (state == ST_DONE) begin
                    agg <= RESP_OKAY;
                end
            end
        end
    end

    cpl_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        cpl_valid |-> (outstanding != '0));

endmodule
